// File: rtl/snn_pkg.sv
// Shared definitions for the SNN input stage: widths, spike entry layout and the LFSR step.
// Only the SPIKE_ZERO_SKIP_EN build option changes behaviour; it is handled in input_spike_encoder.
package snn_pkg;

   localparam int ADDR_W = 10;
   localparam int TS_W   = 8;

   // Right-shift Galois mask for x^8 + x^6 + x^5 + x^4 + 1 (maximal length, 255 states)
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   typedef struct packed {
      logic [ADDR_W-1:0] idx;
      logic              spike;
      logic [TS_W-1:0]   ts;
   } spike_entry_t;

   localparam int ENTRY_W = $bits(spike_entry_t);

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
   endfunction

endpackage

// File: rtl/spike_out_fifo.sv
// Two-entry synchronous FIFO carrying spike entries; exposes occupancy for upstream credit logic.
module spike_out_fifo
   import snn_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push_i,
   input  logic [ENTRY_W-1:0] din_i,
   input  logic               pop_i,
   output logic [ENTRY_W-1:0] dout_o,
   output logic [1:0]         occ_o
);

   logic [ENTRY_W-1:0] mem_q [2];
   logic               wr_ptr_q;
   logic               rd_ptr_q;
   logic [1:0]         occ_q, occ_d;

   always_comb occ_d = occ_q + {1'b0, push_i} - {1'b0, pop_i};

   // NOTE: storage is reset so the head reads as all-zero out of reset; that is visible on spk_*.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) rd_ptr_q <= ~rd_ptr_q;
         occ_q <= occ_d;
      end
   end

   assign dout_o = mem_q[rd_ptr_q];
   assign occ_o  = occ_q;

endmodule

// File: rtl/input_spike_encoder.sv
// Rate-codes input_value_mem into per-neuron spikes, one sweep per timestep, streamed over valid/ready.
// Build option SPIKE_ZERO_SKIP_EN: drop non-firing neurons so only spk_bit=1 entries are emitted.
module input_spike_encoder
   import snn_pkg::*;
#(
   parameter int         INPUT_NEURON_NUM = 1023,
   parameter int         TIMESTEP_NUM     = 16,
   parameter logic [7:0] LFSR_SEED        = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_data,
   output logic              spk_valid,
   input  logic              spk_ready,
   output logic [ADDR_W-1:0] spk_idx,
   output logic              spk_bit,
   output logic [TS_W-1:0]   spk_ts,
   output logic              step_done,
   output logic              done,
   output logic              busy
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_STEP  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(INPUT_NEURON_NUM - 1);
   localparam logic [TS_W-1:0]   LAST_TS  = TS_W'(TIMESTEP_NUM - 1);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [TS_W-1:0]   ts_q, ts_d;
   logic [7:0]        lfsr_q, lfsr_d;
   logic              pend_q, pend_d;

   logic              pop, push, fire, issue;
   logic [1:0]        occ;
   logic [2:0]        credit;
   spike_entry_t      push_entry, head;
   logic [ENTRY_W-1:0] head_raw;

   assign fire = mem_data > lfsr_q;
`ifdef SPIKE_ZERO_SKIP_EN
   assign push = pend_q & fire;
`else
   assign push = pend_q;
`endif

   // A read may only be issued if its result is guaranteed a FIFO slot next cycle.
   assign pop    = spk_valid & spk_ready;
   assign credit = {1'b0, occ} + {2'b00, push} - {2'b00, pop};
   assign issue  = (state_q == S_RUN) & ~mem_wr_en & (credit < 3'd2);

   // The returned read belongs to the index just before the (already advanced) counter.
   always_comb begin
      push_entry.idx   = idx_q - ADDR_W'(1);
      push_entry.spike = fire;
      push_entry.ts    = ts_q;
   end

   // NOTE: every next-state variable gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ts_d    = ts_q;
      lfsr_d  = pend_q ? lfsr_next(lfsr_q) : lfsr_q;
      pend_d  = issue;
      case (state_q)
         S_IDLE: if (start) begin
            state_d = S_RUN;
            idx_d   = '0;
            ts_d    = '0;
            lfsr_d  = LFSR_SEED;
         end
         S_RUN: if (issue) begin
            idx_d = idx_q + ADDR_W'(1);
            if (idx_q == LAST_IDX) state_d = S_DRAIN;
         end
         S_DRAIN: if (occ == 2'd0 && !pend_q) state_d = S_STEP;
         S_STEP: if (ts_q == LAST_TS) begin
            state_d = S_DONE;
         end else begin
            ts_d    = ts_q + TS_W'(1);
            idx_d   = '0;
            state_d = S_RUN;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         ts_q    <= '0;
         lfsr_q  <= LFSR_SEED;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ts_q    <= ts_d;
         lfsr_q  <= lfsr_d;
         pend_q  <= pend_d;
      end
   end

   spike_out_fifo u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (push),
      .din_i  (push_entry),
      .pop_i  (pop),
      .dout_o (head_raw),
      .occ_o  (occ)
   );

   assign head      = head_raw;
   assign mem_addr  = idx_q;
   assign spk_valid = (occ != 2'd0);
   assign spk_idx   = head.idx;
   assign spk_bit   = head.spike;
   assign spk_ts    = head.ts;
   assign step_done = (state_q == S_STEP);
   assign done      = (state_q == S_DONE);
   assign busy      = (state_q == S_RUN) | (state_q == S_DRAIN) | (state_q == S_STEP);

endmodule

// File: tb/tb_input_spike_encoder.sv
// Self-checking bench for input_spike_encoder: precomputed LFSR sequence and a per-neuron sweep model.
module tb_input_spike_encoder;
   import snn_pkg::*;

   localparam int         N    = 1023;
   localparam int         TSN  = 16;
   localparam logic [7:0] SEED = 8'hA5;
`ifdef SPIKE_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n, start, mem_wr_en, spk_ready;
   logic [ADDR_W-1:0] mem_addr, spk_idx;
   logic [7:0]        mem_data;
   logic              spk_valid, spk_bit, step_done, done, busy;
   logic [TS_W-1:0]   spk_ts;

   input_spike_encoder #(.INPUT_NEURON_NUM(N), .TIMESTEP_NUM(TSN), .LFSR_SEED(SEED)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mem_wr_en(mem_wr_en),
      .mem_addr(mem_addr), .mem_data(mem_data),
      .spk_valid(spk_valid), .spk_ready(spk_ready),
      .spk_idx(spk_idx), .spk_bit(spk_bit), .spk_ts(spk_ts),
      .step_done(step_done), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   // input_value_mem: registered read port, one cycle latency
   logic [7:0] mem [0:1023];
   always @(posedge clk) mem_data <= mem[mem_addr];

   int tests_run = 0;
   int fails     = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: the k-th read of a run is compared against the k-th LFSR state (period 255)
   logic [7:0] lfsr_seq [255];
   int  m_idx, m_ts, m_rd, m_steps, m_dones, last_zero;
   bit  mon_en, ff_check;
   bit  stall_q;
   logic [ADDR_W-1:0] prev_idx;
   logic              prev_bit;
   logic [TS_W-1:0]   prev_ts;

   function automatic bit fires(input int i, input int k);
      return mem[i] > lfsr_seq[k % 255];
   endfunction

   task automatic model_init();
      m_idx = 0; m_ts = 0; m_rd = 0; m_steps = 0; m_dones = 0;
      last_zero = -1; stall_q = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst_n || !mon_en) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            check("stall_valid", 32'(spk_valid), 32'd1);
            check("stall_idx", 32'(spk_idx), 32'(prev_idx));
            check("stall_bit", 32'(spk_bit), 32'(prev_bit));
            check("stall_ts", 32'(spk_ts), 32'(prev_ts));
         end
         if (spk_valid && spk_ready) begin
            if (SKIP) begin
               while (m_idx < N && !fires(m_idx, m_rd)) begin
                  m_idx++; m_rd++;
               end
            end
            check("entry_idx", 32'(spk_idx), m_idx);
            check("entry_ts", 32'(spk_ts), m_ts);
            check("entry_bit", 32'(spk_bit), 32'(fires(m_idx, m_rd)));
            if (ff_check && !spk_bit) begin
               if (last_zero >= 0) check("zero_gap", m_rd - last_zero, 255);
               last_zero = m_rd;
            end
            m_idx++; m_rd++;
         end
         if (step_done) begin
            if (SKIP) begin
               while (m_idx < N && !fires(m_idx, m_rd)) begin
                  m_idx++; m_rd++;
               end
            end
            check("entries_per_step", m_idx, N);
            m_ts++; m_idx = 0; m_steps++;
         end
         if (done) begin
            check("steps_at_done", m_steps, TSN);
            m_dones++;
         end
         stall_q  = spk_valid && !spk_ready;
         prev_idx = spk_idx; prev_bit = spk_bit; prev_ts = spk_ts;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("addr_after_start", 32'(mem_addr), 32'd0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v;
      logic [ADDR_W-1:0] a0;
      int cyc;
      bit stalled, restarted;

      v = SEED;
      for (int k = 0; k < 255; k++) begin
         lfsr_seq[k] = v;
         v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
      end

      rst_n = 1'b0; start = 1'b0; mem_wr_en = 1'b0; spk_ready = 1'b1;
      mon_en = 1'b0; ff_check = 1'b0;
      model_init();
      #1;
      check("rst_valid", 32'(spk_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_step_done", 32'(step_done), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_idx", 32'(spk_idx), 32'd0);
      check("rst_ts", 32'(spk_ts), 32'd0);
      check("rst_bit", 32'(spk_bit), 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Run A: all-zero memory, ready held high, write stall and ignored start mid-run
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      model_init();
      mon_en = 1'b1;
      pulse_start();
      cyc = 0; stalled = 1'b0; restarted = 1'b0;
      while (m_dones == 0 && cyc < 20000) begin
         tick(); cyc++;
         start = done;
         if (!stalled && m_ts == 1 && m_idx == 300) begin
            stalled = 1'b1;
            mem_wr_en = 1'b1;
            a0 = mem_addr;
            for (int j = 0; j < 20; j++) begin
               tick(); cyc++;
               check("wr_stall_addr", 32'(mem_addr), 32'(a0));
            end
            mem_wr_en = 1'b0;
         end
         if (!restarted && m_ts == 5 && m_idx == 10) begin
            restarted = 1'b1;
            start = 1'b1;
            tick(); cyc++;
            start = 1'b0;
         end
      end
      start = 1'b0;
      check("runA_done_seen", m_dones, 1);
      tick();
      check("idle_after_done", 32'(busy), 32'd0);
      tick();
      check("no_restart_on_done_start", 32'(busy), 32'd0);
      check("fifo_empty_after_run", 32'(spk_valid), 32'd0);

      // Run B: all-0xFF memory, random backpressure, async reset at idx 500 of timestep 3
      for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
      model_init();
      ff_check = 1'b1;
      pulse_start();
      cyc = 0;
      while (!(m_ts == 3 && m_idx > 500) && cyc < 20000) begin
         tick(); cyc++;
         spk_ready = 1'($urandom_range(0, 1));
      end
      check("runB_reached_ts3_idx500", 32'(m_ts == 3 && m_idx > 500), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(spk_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_step_done", 32'(step_done), 32'd0);
      check("mid_rst_addr", 32'(mem_addr), 32'd0);
      check("mid_rst_idx", 32'(spk_idx), 32'd0);
      check("mid_rst_ts", 32'(spk_ts), 32'd0);
      check("mid_rst_bit", 32'(spk_bit), 32'd0);
      mon_en = 1'b0; ff_check = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_busy", 32'(busy), 32'd0);

      // Run C: restart from seed, firing neurons only at 0, 7 and 1022, mild backpressure
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[0] = 8'hFF; mem[7] = 8'hFF; mem[1022] = 8'hFF;
      model_init();
      mon_en = 1'b1;
      spk_ready = 1'b1;
      pulse_start();
      cyc = 0;
      while (m_dones == 0 && cyc < 30000) begin
         tick(); cyc++;
         spk_ready = ($urandom_range(0, 3) != 0);
      end
      spk_ready = 1'b1;
      check("runC_done_seen", m_dones, 1);
      check("runC_steps", m_steps, TSN);
      tick();
      check("runC_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
